// File: rtl/struct_array_sched.sv
// Round-robin single-entry write scheduler over a packed array of a_struct_t, with a
// default-pattern sweep after reset. Optional parity output: STRUCT_ARRAY_SCHED_PARITY_EN.
package TEST_TYPES;
  typedef struct packed {
    logic stuff;
  } a_struct_t;
endpackage

module struct_array_sched #(
  parameter int unsigned N    = 4,
  parameter int unsigned NREQ = 3,
  localparam int unsigned IW  = $clog2(N),
  localparam int unsigned RW  = $clog2(NREQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         init_start,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*IW-1:0]           req_idx,
  input  logic [NREQ-1:0]              req_data,
  output logic [NREQ-1:0]              req_ready,
  output TEST_TYPES::a_struct_t [N-1:0] a_out,
  output logic                         init_done,
  output logic                         err_oob
`ifdef STRUCT_ARRAY_SCHED_PARITY_EN
  ,
  output logic                         parity
`endif
);

  typedef enum logic {StInit, StRun} state_e;

  state_e                        r_state, w_state_d;
  logic [IW-1:0]                 r_ptr, w_ptr_d;
  logic [RW-1:0]                 r_rr, w_rr_d;
  TEST_TYPES::a_struct_t [N-1:0] r_a, w_a_d;
  logic                          r_err, w_err_d;

  logic [NREQ-1:0] w_ready;
  logic            w_grant_any;
  int unsigned     w_sel_r;
  logic [IW-1:0]   w_sel_idx;
  logic            w_sel_data;
  logic            w_oob;

  // Search starts at rr_ptr and wraps; first valid requester wins.
  always_comb begin : p_grant
    w_ready     = '0;
    w_grant_any = 1'b0;
    w_sel_r     = 0;
    w_sel_idx   = '0;
    w_sel_data  = 1'b0;
    if (r_state == StRun && !init_start) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!w_grant_any && req_valid[(32'(r_rr) + i) % NREQ]) begin
          w_grant_any = 1'b1;
          w_sel_r     = (32'(r_rr) + i) % NREQ;
        end
      end
      if (w_grant_any) begin
        w_ready[w_sel_r] = 1'b1;
        w_sel_idx        = req_idx[w_sel_r*IW +: IW];
        w_sel_data       = req_data[w_sel_r];
      end
    end
  end

  assign w_oob = (32'(w_sel_idx) >= N);

  always_comb begin : p_next
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_rr_d    = r_rr;
    w_a_d     = r_a;
    w_err_d   = 1'b0;
    unique case (r_state)
      StInit: begin
        if (init_start) begin
          w_ptr_d = '0;
        end else begin
          w_a_d[r_ptr].stuff = r_ptr[0];
          if (r_ptr == IW'(N - 1)) begin
            w_state_d = StRun;
            w_ptr_d   = '0;
          end else begin
            w_ptr_d = r_ptr + IW'(1);
          end
        end
      end
      StRun: begin
        if (init_start) begin
          w_state_d = StInit;
          w_ptr_d   = '0;
        end else if (w_grant_any) begin
          w_rr_d = RW'((w_sel_r + 1) % NREQ);
          if (w_oob) begin
            w_err_d = 1'b1;
          end else begin
            w_a_d[w_sel_idx].stuff = w_sel_data;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StInit;
      r_ptr   <= '0;
      r_rr    <= '0;
      r_a     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_rr    <= w_rr_d;
      r_a     <= w_a_d;
      r_err   <= w_err_d;
    end
  end

`ifdef STRUCT_ARRAY_SCHED_PARITY_EN
  logic r_par;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else begin
      r_par <= ^w_a_d;
    end
  end

  assign parity = r_par;
`endif

  assign req_ready = w_ready;
  assign a_out     = r_a;
  assign init_done = (r_state == StRun);
  assign err_oob   = r_err;

endmodule

// File: tb/tb_struct_array_sched.sv
// Randomized bench for struct_array_sched: an N=4 and an N=3 instance share stimulus and are
// each checked every cycle against a behavioural model.
module tb_struct_array_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_start = 1'b0;
  logic [2:0] req_valid = '0;
  logic [5:0] req_idx = '0;
  logic [2:0] req_data = '0;

  logic [2:0] rdy4, rdy3;
  TEST_TYPES::a_struct_t [3:0] a4;
  TEST_TYPES::a_struct_t [2:0] a3;
  logic done4, done3, err4, err3;
`ifdef STRUCT_ARRAY_SCHED_PARITY_EN
  logic par4, par3;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  struct_array_sched #(.N(4), .NREQ(3)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_start (init_start),
    .req_valid  (req_valid),
    .req_idx    (req_idx),
    .req_data   (req_data),
    .req_ready  (rdy4),
    .a_out      (a4),
    .init_done  (done4),
    .err_oob    (err4)
`ifdef STRUCT_ARRAY_SCHED_PARITY_EN
    ,
    .parity     (par4)
`endif
  );

  struct_array_sched #(.N(3), .NREQ(3)) u_dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_start (init_start),
    .req_valid  (req_valid),
    .req_idx    (req_idx),
    .req_data   (req_data),
    .req_ready  (rdy3),
    .a_out      (a3),
    .init_done  (done3),
    .err_oob    (err3)
`ifdef STRUCT_ARRAY_SCHED_PARITY_EN
    ,
    .parity     (par3)
`endif
  );

  // Behavioural model, one slot per instance (0: N=4, 1: N=3).
  int unsigned nn[2] = '{4, 3};
  bit          m_run[2];
  int unsigned m_ptr[2];
  int unsigned m_rr[2];
  bit          m_err[2];
  bit          m_par[2];
  bit          m_a[2][4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_grant(input int k, input logic is, input logic [2:0] v);
    int unsigned r;
    if (!m_run[k] || is) return 3'b000;
    for (int i = 0; i < 3; i++) begin
      r = (m_rr[k] + i) % 3;
      if (v[r]) return 3'b001 << r;
    end
    return 3'b000;
  endfunction

  task automatic model_update(input int k, input logic rn, input logic is,
                              input logic [2:0] v, input logic [5:0] ix, input logic [2:0] d);
    logic [2:0]  g;
    int unsigned id;
    g = exp_grant(k, is, v);
    if (!rn) begin
      m_run[k] = 0; m_ptr[k] = 0; m_rr[k] = 0; m_err[k] = 0;
      for (int i = 0; i < 4; i++) m_a[k][i] = 0;
    end else if (!m_run[k]) begin
      m_err[k] = 0;
      if (is) begin
        m_ptr[k] = 0;
      end else begin
        m_a[k][m_ptr[k]] = bit'(m_ptr[k] % 2);
        m_ptr[k]++;
        if (m_ptr[k] == nn[k]) begin
          m_ptr[k] = 0;
          m_run[k] = 1;
        end
      end
    end else if (is) begin
      m_run[k] = 0; m_ptr[k] = 0; m_err[k] = 0;
    end else begin
      m_err[k] = 0;
      for (int r = 0; r < 3; r++) begin
        if (g[r]) begin
          id = 32'(ix[r*2 +: 2]);
          if (id < nn[k]) m_a[k][id] = d[r];
          else m_err[k] = 1;
          m_rr[k] = (r + 1) % 3;
        end
      end
    end
    m_par[k] = 0;
    for (int i = 0; i < 4; i++) if (i < nn[k]) m_par[k] ^= m_a[k][i];
  endtask

  task automatic step(input logic rn, input logic is, input logic [2:0] v,
                      input logic [5:0] ix, input logic [2:0] d);
    logic [3:0] ga, ea;
    @(negedge clk);
    rst_n = rn; init_start = is; req_valid = v; req_idx = ix; req_data = d;
    #1;
    for (int k = 0; k < 2; k++) begin
      ga = '0; ea = '0;
      for (int i = 0; i < 4; i++) begin
        if (k == 0) ga[i] = a4[i].stuff;
        else if (i < 3) ga[i] = a3[i].stuff;
        if (i < nn[k]) ea[i] = m_a[k][i];
      end
      check($sformatf("n%0d_ready", nn[k]), 32'(k == 0 ? rdy4 : rdy3), 32'(exp_grant(k, is, v)));
      check($sformatf("n%0d_a_out", nn[k]), 32'(ga), 32'(ea));
      check($sformatf("n%0d_init_done", nn[k]), 32'(k == 0 ? done4 : done3), 32'(m_run[k]));
      check($sformatf("n%0d_err_oob", nn[k]), 32'(k == 0 ? err4 : err3), 32'(m_err[k]));
`ifdef STRUCT_ARRAY_SCHED_PARITY_EN
      check($sformatf("n%0d_parity", nn[k]), 32'(k == 0 ? par4 : par3), 32'(m_par[k]));
`endif
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k, rn, is, v, ix, d);
  endtask

  initial begin
    logic       rn, is;
    logic [2:0] v, d;
    logic [5:0] ix;
    // Unchecked reset so both DUTs leave X, then align the model.
    repeat (2) @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k, 1'b0, 1'b0, 3'b000, 6'd0, 3'b000);

    step(1'b0, 1'b0, 3'b111, 6'd0, 3'b000);
    // Sweep with all requesters asking; no grants until RUN.
    repeat (5) step(1'b1, 1'b0, 3'b111, 6'b11_10_01, 3'b101);
    // Hold all valid: rotating grants.
    repeat (6) step(1'b1, 1'b0, 3'b111, 6'b01_00_10, 3'b010);
    // Two requesters hit entry 2 with different data.
    repeat (3) step(1'b1, 1'b0, 3'b011, 6'b00_10_10, 3'b010);
    // Out-of-range index (only for N=3).
    repeat (2) step(1'b1, 1'b0, 3'b100, 6'b11_11_11, 3'b111);
    step(1'b1, 1'b0, 3'b000, 6'd0, 3'b000);
    // Re-sweep requested while a request is pending.
    step(1'b1, 1'b1, 3'b001, 6'b00_00_01, 3'b001);
    repeat (5) step(1'b1, 1'b0, 3'b001, 6'b00_00_01, 3'b001);
    // Reset in the middle of a sweep.
    step(1'b1, 1'b1, 3'b000, 6'd0, 3'b000);
    repeat (2) step(1'b1, 1'b0, 3'b000, 6'd0, 3'b000);
    step(1'b0, 1'b0, 3'b111, 6'd0, 3'b111);
    repeat (6) step(1'b1, 1'b0, 3'b000, 6'd0, 3'b000);
    // init_start during the sweep restarts it.
    step(1'b1, 1'b1, 3'b000, 6'd0, 3'b000);
    repeat (2) step(1'b1, 1'b0, 3'b000, 6'd0, 3'b000);
    step(1'b1, 1'b1, 3'b000, 6'd0, 3'b000);
    repeat (6) step(1'b1, 1'b0, 3'b000, 6'd0, 3'b000);

    for (int c = 0; c < 600; c++) begin
      rn = ($urandom_range(0, 79) != 0);
      is = ($urandom_range(0, 24) == 0);
      v  = 3'($urandom);
      ix = 6'($urandom);
      d  = 3'($urandom);
      step(rn, is, v, ix, d);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/struct_array_sched.md
Name: struct_array_sched

Overview:
- Round-robin write scheduler that owns a packed array of TEST_TYPES::a_struct_t (one-bit field `stuff` per entry).
- After reset it sweeps the array with the default pattern `stuff = index[0]`.
- Afterwards it shares single-entry write access between NREQ requesters, one grant per cycle.
- Sits between requesters and any consumer of the array (drop-in producer of an `a_out` array).

Parameters:
- N, 4, number of array entries (>=2).
- NREQ, 3, number of requesters (>=2).
- IW, $clog2(N), index width per requester (local, derived).

Ports:
- clk  input  1  clock, all state on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- init_start  input  1  request re-sweep of default pattern.
- req_valid  input  NREQ  per-requester write request.
- req_idx  input  NREQ*IW  packed entry indices; requester r uses bits [r*IW +: IW].
- req_data  input  NREQ  value for `stuff`, bit r belongs to requester r.
- req_ready  output  NREQ  one-hot grant (combinational from state, rr_ptr, req_valid).
- a_out  output  TEST_TYPES::a_struct_t [N-1:0]  scheduled array.
- init_done  output  1  high while in RUN.
- err_oob  output  1  one-cycle pulse: granted write had index >= N (only possible when N is not a power of 2).

Behaviour:
- States: INIT, RUN. Registers: state, sweep ptr (IW bits), rr_ptr ($clog2(NREQ) bits), a_out, err_oob.
- Reset, when rst_n is low at posedge:
  - state=INIT, ptr=0, rr_ptr=0.
  - a_out all-zero, init_done=0, err_oob=0.
  - Reset dominates every other input.
  - Reset mid-INIT or mid-RUN restarts the sweep from 0.
- INIT:
  - Each cycle: a_out[ptr].stuff <= ptr[0]; ptr <= ptr+1.
  - After writing ptr==N-1: state <= RUN, ptr <= 0.
  - Sweep takes exactly N cycles; init_done first reads 1 on the (N+1)th posedge after rst_n rises.
  - req_ready=0 throughout; requests are ignored, not queued.
  - init_start during INIT: ptr <= 0; already-written entries are rewritten.
- RUN:
  - Grant goes to the first r with req_valid[r]=1, searching r = rr_ptr, rr_ptr+1, ... modulo NREQ; req_ready has exactly that bit set.
  - No valid requests: req_ready=0 and rr_ptr holds.
  - Transfer occurs when req_valid[r] & req_ready[r] at posedge.
  - On a transfer, if idx < N: a_out[idx].stuff <= req_data[r]; err_oob <= 0.
  - On a transfer, if idx >= N: array unchanged; err_oob <= 1.
  - Either way rr_ptr <= (r+1) mod NREQ.
  - err_oob is 0 on every cycle without an out-of-range transfer.
  - Write latency: new value visible on a_out one cycle after the transfer edge.
  - Losers keep req_valid asserted; their payload must stay stable until granted.
  - Starvation bound: a continuously valid requester is granted within NREQ cycles.
- init_start in RUN:
  - Wins over any request that cycle; no grant is issued (req_ready forced 0 that cycle).
  - Next state INIT, ptr=0, init_done=0.
  - rr_ptr is preserved.
- Index width: req_idx slices are IW bits, compared unsigned against N.

Optional Feature:
- Macro STRUCT_ARRAY_SCHED_PARITY_EN.
- Defined:
  - Extra output `parity` (1 bit) = registered XOR of all a_out[i].stuff, updated the same edge as a_out.
  - Reset value 0.
  - After an INIT sweep with N even: value N/2 mod 2.
- Undefined: no `parity` port and no parity logic; all other behaviour identical.

Test Plan:
- Reset then release, N=4: a_out sequence during INIT ends at {1,0,1,0} (entries [3:0]); init_done=1 exactly 4 cycles after release; req_ready=0 during INIT even with req_valid=3'b111.
- RUN, req_valid=3'b111 held for 6 cycles, rr_ptr=0 → grants 0,1,2,0,1,2; req_ready always one-hot.
- Requester 1 writes idx=2 data=1 while requester 0 writes idx=2 data=0 in later grant → a_out[2] follows grant order: 1 then 0, each visible one cycle after its transfer.
- N=3 build, req_idx=3 granted → a_out unchanged, err_oob high for exactly 1 cycle, rr_ptr advances.
- init_start pulsed in RUN with req_valid=3'b001 → no grant that cycle; a_out returns to {0,1,0} pattern (N=3) after 3 cycles; init_done low for those 3 cycles.
- rst_n low for 1 cycle mid-INIT (ptr=2) → a_out all-zero next cycle, sweep restarts at ptr=0; with STRUCT_ARRAY_SCHED_PARITY_EN defined, parity=0 after reset and 0 after a complete N=4 sweep.
